// File: rtl/config_pkg.sv
// Shared configuration for the LSU store path: store-buffer depth, pointer width, entry layout.
// Pure type/constant package, no logic.
// Entry fields are stored exactly as the LSU presents them (lane-aligned data).
package config_pkg;

  localparam int unsigned NR_SB_ENTRIES = 8;
  localparam int unsigned POINTER_SIZE  = $clog2(NR_SB_ENTRIES);

  typedef struct packed {
    logic [63:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [1:0]  size;
  } sb_entry_t;

endpackage

// File: rtl/sb_offset_match.sv
// Parallel page-offset comparators over all store-buffer entries, masked by entry validity.
// Latency: combinational.
// Backpressure: none, the hit feeds the LSU load stall.
module sb_offset_match #(
  parameter int unsigned DEPTH = 8
) (
  input  logic [DEPTH-1:0]      ent_vld,
  input  logic [DEPTH-1:0][8:0] ent_off,
  input  logic [8:0]            ld_off,
  output logic                  hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit = hit | (ent_vld[i] & (ent_off[i] == ld_off));
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: holds speculative stores until commit, drains committed ones in order to the D$.
// Latency: push N -> commit_ready_o N+1, earliest req_o N+2; one drain per cycle sustained.
// Backpressure: ready_o from registered occupancy; req_o held with stable payload until gnt_i. SB_FWD_EN adds ld_hit_o.
module store_buffer
  import config_pkg::*;
#(
  parameter int unsigned DEPTH = NR_SB_ENTRIES,
  parameter int unsigned PTR_W = POINTER_SIZE
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [63:0] paddr_i,
  input  logic [63:0] data_i,
  input  logic [7:0]  be_i,
  input  logic [1:0]  size_i,
  input  logic        commit_i,
  output logic        commit_ready_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic [63:0] addr_o,
  output logic [63:0] wdata_o,
  output logic [7:0]  be_o,
  output logic [1:0]  size_o,
  output logic        empty_o,
  output logic        no_st_pending_o
`ifdef SB_FWD_EN
  ,
  input  logic [11:0] ld_offset_i,
  output logic        ld_hit_o
`endif
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  sb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, commit_ptr, drain_ptr;
  logic [PTR_W-1:0] commit_ptr_nxt;
  logic [PTR_W:0]   spec_cnt, com_cnt, total_cnt;
  logic             push, commit, drain;
  sb_entry_t        head;

  assign total_cnt       = spec_cnt + com_cnt;
  assign ready_o         = total_cnt < DEPTH_CNT;
  assign commit_ready_o  = spec_cnt != '0;
  assign req_o           = com_cnt != '0;
  assign empty_o         = (spec_cnt == '0) & (com_cnt == '0);
  assign no_st_pending_o = com_cnt == '0;

  // A push racing a flush is speculative by definition, so it is dropped.
  assign push   = valid_i & ready_o & ~flush_i;
  assign commit = commit_i & commit_ready_o;
  assign drain  = req_o & gnt_i;

  assign commit_ptr_nxt = commit_ptr + PTR_W'(commit);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= '{paddr: paddr_i, data: data_i, be: be_i, size: size_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drain_ptr  <= '0;
      spec_cnt   <= '0;
      com_cnt    <= '0;
    end else begin
      commit_ptr <= commit_ptr_nxt;
      drain_ptr  <= drain_ptr + PTR_W'(drain);
      com_cnt    <= com_cnt + (PTR_W+1)'(commit) - (PTR_W+1)'(drain);
      if (flush_i) begin
        // Rewind to just past the last committed entry, including one committed this cycle.
        wr_ptr   <= commit_ptr_nxt;
        spec_cnt <= '0;
      end else begin
        wr_ptr   <= wr_ptr + PTR_W'(push);
        spec_cnt <= spec_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(commit);
      end
    end
  end

  assign head    = mem[drain_ptr];
  assign addr_o  = head.paddr;
  assign wdata_o = head.data;
  assign be_o    = head.be;
  assign size_o  = head.size;

`ifdef SB_FWD_EN
  logic [DEPTH-1:0]      ent_vld;
  logic [DEPTH-1:0][8:0] ent_off;
  logic [PTR_W-1:0]      rel_idx;
  logic                  ld_off_unused;

  // An entry is live when its distance from the drain head is below total occupancy.
  always_comb begin
    ent_vld = '0;
    ent_off = '0;
    rel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel_idx    = PTR_W'(i) - drain_ptr;
      ent_vld[i] = {1'b0, rel_idx} < total_cnt;
      ent_off[i] = mem[i].paddr[11:3];
    end
  end

  assign ld_off_unused = ^ld_offset_i[2:0];

  sb_offset_match #(
    .DEPTH (DEPTH)
  ) u_offset_match (
    .ent_vld (ent_vld),
    .ent_off (ent_off),
    .ld_off  (ld_offset_i[11:3]),
    .hit     (ld_hit_o)
  );
`endif

  commit_without_spec: assert property (@(posedge clk_i) disable iff (!rst_ni)
    commit_i |-> commit_ready_o);

endmodule
